decode: RTL and testbench

Instruction decode stage, directly downstream of the wishbone instruction fetch unit. It sequences the fetch unit by driving its enable and PC. It captures the single-cycle completed pulse and splits the instruction word into registered fields for the execute stage. A one-entry valid/ready output register and a flush/redirect path from execute complete the stage.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/decode_if.sv | 30 +++
 rtl/decode_fields.sv | 28 ++
 rtl/decode.sv | 99 +++++++++
 tb/tb_decode.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the decode stage: opcode values, instruction field
// positions, FSM state encoding and the decoded-field bundle.
package cpu_pkg;

    localparam logic [5:0] OP_ALU_R  = 6'h00;
    localparam logic [5:0] OP_ALU_I  = 6'h01;
    localparam logic [5:0] OP_LOAD   = 6'h02;
    localparam logic [5:0] OP_STORE  = 6'h03;
    localparam logic [5:0] OP_BRANCH = 6'h04;
    localparam logic [5:0] OP_JUMP   = 6'h05;
    localparam logic [5:0] OP_NOP    = 6'h3F;

    localparam int OPC_MSB  = 31;
    localparam int RD_MSB   = 25;
    localparam int RS1_MSB  = 20;
    localparam int RS2_MSB  = 15;
    localparam int IMM_MSB  = 15;
    localparam int JOFF_MSB = 25;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        logic signed [15:0] s;
        s = $signed(v);
        return 32'(s);
    endfunction

    function automatic logic signed [31:0] sext28(input logic [27:0] v);
        logic signed [27:0] s;
        s = $signed(v);
        return 32'(s);
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side signal bundle of the decode stage.
interface decode_if;
    logic        o_fetch_enable;
    logic [31:0] o_fetch_pc;
    logic [31:0] i_fetch_instruction;
    logic        i_fetch_completed;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [5:0]  o_opcode;
    logic [4:0]  o_rd;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [31:0] o_imm;
    logic        o_illegal;

    modport master (
        output o_fetch_enable, o_fetch_pc, o_valid, o_pc, o_opcode,
               o_rd, o_rs1, o_rs2, o_imm, o_illegal,
        input  i_fetch_instruction, i_fetch_completed, i_flush, i_flush_pc, i_ready
    );

    modport slave (
        input  o_fetch_enable, o_fetch_pc, o_valid, o_pc, o_opcode,
               o_rd, o_rs1, o_rs2, o_imm, o_illegal,
        output i_fetch_instruction, i_fetch_completed, i_flush, i_flush_pc, i_ready
    );
endinterface

// File: rtl/decode_fields.sv
// Combinational instruction splitter: extracts register fields and builds the
// immediate for the opcode class; unknown opcodes are flagged illegal.
module decode_fields
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    always_comb begin
        dec_o         = '0;
        dec_o.opcode  = instr_i[OPC_MSB -: 6];
        dec_o.rd      = instr_i[RD_MSB -: 5];
        dec_o.rs1     = instr_i[RS1_MSB -: 5];
        dec_o.rs2     = instr_i[RS2_MSB -: 5];
        dec_o.imm     = '0;
        dec_o.illegal = 1'b0;
        case (instr_i[OPC_MSB -: 6])
            OP_ALU_R, OP_NOP: dec_o.imm = '0;
            OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH:
                dec_o.imm = sext16(instr_i[IMM_MSB -: 16]);
            // Jump offset is a word offset; scale to bytes before extending.
            OP_JUMP: dec_o.imm = sext28({instr_i[JOFF_MSB -: 26], 2'b00});
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode.sv
// Decode stage: sequences the fetch unit, registers decoded fields of each
// completed instruction and offers them to execute through a one-entry slot.
module decode
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset,
    decode_if.master bus
);

    state_t      state_q;
    logic        fetch_en_q;
    logic [31:0] fetch_pc_q;
    logic        valid_q;
    logic [31:0] pc_q;
    dec_t        fields_d;
    dec_t        fields_q;

    decode_fields u_fields (
        .instr_i (bus.i_fetch_instruction),
        .dec_o   (fields_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_en_q <= 1'b0;
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            fields_q   <= '0;
        end else if (bus.i_flush) begin
            valid_q    <= 1'b0;
            fetch_pc_q <= bus.i_flush_pc;
            case (state_q)
                S_WAIT: begin
                    // A fetch still in flight must be drained before redirecting.
                    if (bus.i_fetch_completed) begin
                        fetch_en_q <= 1'b1;
                        state_q    <= S_WAIT;
                    end else begin
                        fetch_en_q <= 1'b0;
                        state_q    <= S_DROP;
                    end
                end
                S_DROP: state_q <= S_DROP;
                default: begin
                    fetch_en_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    fetch_en_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_fetch_completed) begin
                        fields_q   <= fields_d;
                        pc_q       <= fetch_pc_q;
                        valid_q    <= 1'b1;
                        fetch_en_q <= 1'b0;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (valid_q && bus.i_ready) begin
                        valid_q    <= 1'b0;
                        fetch_en_q <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_DROP: begin
                    if (bus.i_fetch_completed) begin
                        fetch_en_q <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_fetch_enable = fetch_en_q;
    assign bus.o_fetch_pc     = fetch_pc_q;
    assign bus.o_valid        = valid_q;
    assign bus.o_pc           = pc_q;
    assign bus.o_opcode       = fields_q.opcode;
    assign bus.o_rd           = fields_q.rd;
    assign bus.o_rs1          = fields_q.rs1;
    assign bus.o_rs2          = fields_q.rs2;
    assign bus.o_imm          = fields_q.imm;
    assign bus.o_illegal      = fields_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage with a flag-based reference model.
module tb_decode;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_if bus ();

    decode #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: plain flags describing what the stage is doing.
    logic        m_idle, m_en, m_drop, m_valid, m_illegal;
    logic [31:0] m_fpc, m_pc, m_imm;
    logic [5:0]  m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;

    task automatic ref_decode(input logic [31:0] instr);
        longint u;
        longint v;
        u = instr;
        m_op      = 6'(u / 64'd67108864);
        m_rd      = 5'((u / 64'd2097152) % 64'd32);
        m_rs1     = 5'((u / 64'd65536) % 64'd32);
        m_rs2     = 5'((u / 64'd2048) % 64'd32);
        m_illegal = 1'b0;
        v = 0;
        case (m_op)
            6'd1, 6'd2, 6'd3, 6'd4: begin
                v = u % 64'd65536;
                if (v >= 32768) v = v - 65536;
            end
            6'd5: begin
                v = (u % 64'd67108864) * 4;
                if (v >= 64'd134217728) v = v - 64'd268435456;
            end
            6'd0, 6'd63: v = 0;
            default: m_illegal = 1'b1;
        endcase
        m_imm = v[31:0];
    endtask

    task automatic model_step();
        if (!reset) begin
            m_idle = 1; m_en = 0; m_drop = 0; m_valid = 0; m_fpc = 32'h100;
            m_pc = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_illegal = 0;
        end else if (bus.i_flush) begin
            m_valid = 0;
            m_fpc   = bus.i_flush_pc;
            if (m_drop) begin
            end else if (m_en && !bus.i_fetch_completed) begin
                m_en = 0; m_drop = 1;
            end else begin
                m_en = 1; m_idle = 0;
            end
        end else if (m_idle) begin
            m_en = 1; m_idle = 0;
        end else if (m_drop) begin
            if (bus.i_fetch_completed) begin m_drop = 0; m_en = 1; end
        end else if (m_valid) begin
            if (bus.i_ready) begin m_valid = 0; m_en = 1; end
        end else if (m_en && bus.i_fetch_completed) begin
            ref_decode(bus.i_fetch_instruction);
            m_pc = m_fpc; m_valid = 1; m_en = 0; m_fpc = m_fpc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [119:0] act, exp;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            act = {bus.o_fetch_enable, bus.o_fetch_pc, bus.o_valid, bus.o_pc, bus.o_opcode,
                   bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_imm, bus.o_illegal};
            exp = {m_en, m_fpc, m_valid, m_pc, m_op, m_rd, m_rs1, m_rs2, m_imm, m_illegal};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] instr);
        bus.i_fetch_completed   = 1'b1;
        bus.i_fetch_instruction = instr;
        @(negedge clk);
        bus.i_fetch_completed   = 1'b0;
    endtask

    task automatic accept();
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
    endtask

    logic [31:0] vecs [4] = '{32'h0C22_7FFF, 32'h1000_0001, 32'h00A5_A5A5, 32'h0400_0001};

    initial begin
        reset = 1'b0;
        bus.i_fetch_instruction = '0;
        bus.i_fetch_completed   = 1'b0;
        bus.i_flush             = 1'b0;
        bus.i_flush_pc          = '0;
        bus.i_ready             = 1'b0;
        cyc(3);
        chk("rst_en", 32'(bus.o_fetch_enable), 32'd0);
        chk("rst_fpc", bus.o_fetch_pc, 32'h100);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_imm", bus.o_imm, 32'd0);

        reset = 1'b1;
        cyc(1);
        chk("start_en", 32'(bus.o_fetch_enable), 32'd1);
        chk("start_fpc", bus.o_fetch_pc, 32'h100);
        cyc(1);
        pulse(32'h0443_8000);
        chk("d1_valid", 32'(bus.o_valid), 32'd1);
        chk("d1_op", 32'(bus.o_opcode), 32'h01);
        chk("d1_rd", 32'(bus.o_rd), 32'd2);
        chk("d1_rs1", 32'(bus.o_rs1), 32'd3);
        chk("d1_imm", bus.o_imm, 32'hFFFF_8000);
        chk("d1_pc", bus.o_pc, 32'h100);
        chk("d1_fpc", bus.o_fetch_pc, 32'h104);
        chk("model_imm", m_imm, 32'hFFFF_8000);

        cyc(5);
        chk("stall_valid", 32'(bus.o_valid), 32'd1);
        chk("stall_en", 32'(bus.o_fetch_enable), 32'd0);
        chk("stall_imm", bus.o_imm, 32'hFFFF_8000);
        accept();
        chk("acc_valid", 32'(bus.o_valid), 32'd0);
        chk("acc_en", 32'(bus.o_fetch_enable), 32'd1);

        bus.i_flush = 1'b1; bus.i_flush_pc = 32'h200;
        cyc(1);
        bus.i_flush = 1'b0;
        chk("drop_en", 32'(bus.o_fetch_enable), 32'd0);
        chk("drop_fpc", bus.o_fetch_pc, 32'h200);
        cyc(1);
        pulse(32'h1234_5678);
        chk("drop_valid", 32'(bus.o_valid), 32'd0);
        chk("drop_reen", 32'(bus.o_fetch_enable), 32'd1);
        pulse(32'h0800_0010);
        chk("redir_pc", bus.o_pc, 32'h200);
        chk("redir_imm", bus.o_imm, 32'h10);

        bus.i_flush = 1'b1; bus.i_ready = 1'b1; bus.i_flush_pc = 32'h300;
        cyc(1);
        bus.i_flush = 1'b0; bus.i_ready = 1'b0;
        chk("hflush_valid", 32'(bus.o_valid), 32'd0);
        chk("hflush_fpc", bus.o_fetch_pc, 32'h300);

        bus.i_flush = 1'b1; bus.i_flush_pc = 32'h400;
        bus.i_fetch_completed = 1'b1; bus.i_fetch_instruction = 32'h0;
        cyc(1);
        bus.i_flush = 1'b0; bus.i_fetch_completed = 1'b0;
        chk("cflush_valid", 32'(bus.o_valid), 32'd0);
        chk("cflush_en", 32'(bus.o_fetch_enable), 32'd1);
        chk("cflush_fpc", bus.o_fetch_pc, 32'h400);

        pulse(32'h17FF_FFFF);
        chk("jump_op", 32'(bus.o_opcode), 32'h05);
        chk("jump_imm", bus.o_imm, 32'hFFFF_FFFC);
        chk("jump_pc", bus.o_pc, 32'h400);
        chk("model_jimm", m_imm, 32'hFFFF_FFFC);
        accept();

        pulse(32'hA842_1234);
        chk("ill_flag", 32'(bus.o_illegal), 32'd1);
        chk("ill_op", 32'(bus.o_opcode), 32'h2A);
        chk("ill_imm", bus.o_imm, 32'd0);
        accept();

        foreach (vecs[i]) begin
            pulse(vecs[i]);
            cyc(1);
            accept();
        end

        bus.i_flush = 1'b1; bus.i_flush_pc = 32'hFFFF_FFFC;
        cyc(1);
        bus.i_flush = 1'b0;
        pulse(32'hDEAD_BEEF);
        pulse(32'hFC00_0000);
        chk("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
        chk("wrap_fpc", bus.o_fetch_pc, 32'h0);
        chk("nop_op", 32'(bus.o_opcode), 32'h3F);
        accept();

        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("mrst_en", 32'(bus.o_fetch_enable), 32'd0);
        chk("mrst_fpc", bus.o_fetch_pc, 32'h100);
        chk("mrst_pc", bus.o_pc, 32'd0);
        chk("mrst_op", 32'(bus.o_opcode), 32'd0);
        reset = 1'b1;
        bus.i_fetch_completed = 1'b1; bus.i_fetch_instruction = 32'h0443_8000;
        cyc(1);
        bus.i_fetch_completed = 1'b0;
        chk("stray_valid", 32'(bus.o_valid), 32'd0);
        chk("stray_en", 32'(bus.o_fetch_enable), 32'd1);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
